// File: rtl/icache_req_arbiter.sv
// icache_req_arbiter: shares one i-cache request/response port between the
// fetch stage (requester 0) and the next-line prefetcher (requester 1).
// The address channel is arbitrated round-robin with a hold-until-accepted
// lock. An in-order ID FIFO routes each response back to its issuer.
// Responses to requests issued before a flush are silently dropped.
// Optional feature macro: ICACHE_ARB_PERF_EN adds saturating performance counters.
module icache_req_arbiter #(
  parameter int  ADDR_W       = 32,
  parameter int  MAX_OUT      = 4,
  parameter type icache_out_t = logic [31:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  output icache_out_t            rsp_data_o,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [ADDR_W-1:0]      addr_o,
  output logic                   addr_valid_o,
  input  logic                   addr_ready_i,
  input  icache_out_t            data_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o
`ifdef ICACHE_ARB_PERF_EN
  ,
  output logic [1:0][31:0]       perf_grant_o,
  output logic [31:0]            perf_stall_o,
  output logic [31:0]            perf_squash_o
`endif
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arbState_e;

  arbState_e        state_q, state_d;
  logic             lockId_q, lockId_d;
  logic             flushSeen_q, flushSeen_d;
  logic             rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             idMem_q [MAX_OUT];
  logic             sqMem_q [MAX_OUT];

  logic sel;
  logic push;
  logic pushSquash;
  logic pop;
  logic headId;
  logic headSq;
  logic fifoFull;
  logic fifoEmpty;

  assign fifoFull  = (count_q == CNT_W'(MAX_OUT));
  assign fifoEmpty = (count_q == '0);

  // Address-channel arbitration: select a requester, drive the i-cache
  // address, and compute the lock / sticky-flush / round-robin next state.
  always_comb begin
    sel          = 1'b0;
    addr_valid_o = 1'b0;
    req_ready_o  = 2'b00;
    push         = 1'b0;
    pushSquash   = 1'b0;
    state_d      = ARB_IDLE;
    lockId_d     = lockId_q;
    flushSeen_d  = 1'b0;
    rrPtr_d      = rrPtr_q;

    if (state_q == ARB_LOCKED) begin
      sel = lockId_q;
    end else if (&req_valid_i) begin
      sel = rrPtr_q;
    end else begin
      sel = req_valid_i[1];
    end

    if (state_q == ARB_LOCKED) begin
      addr_valid_o = 1'b1;
    end else begin
      addr_valid_o = (|req_valid_i) && !fifoFull && !flush_i;
    end

    push           = addr_valid_o && addr_ready_i;
    req_ready_o[0] = push && (sel == 1'b0);
    req_ready_o[1] = push && (sel == 1'b1);
    pushSquash     = flush_i || flushSeen_q;

    if (addr_valid_o && !addr_ready_i) begin
      state_d     = ARB_LOCKED;
      lockId_d    = sel;
      flushSeen_d = flushSeen_q || flush_i;
    end

    if (push) begin
      rrPtr_d = ~sel;
    end
  end

  assign addr_o = req_addr_i[sel];

  // Response routing: forward the cache response to the head entry's
  // requester, or swallow it when the head was squashed by a flush.
  always_comb begin
    rsp_valid_o  = 2'b00;
    rsp_data_o   = '0;
    data_ready_o = 1'b0;
    pop          = 1'b0;
    headId       = idMem_q[rdPtr_q];
    headSq       = sqMem_q[rdPtr_q];
    if (!fifoEmpty) begin
      if (headSq) begin
        data_ready_o = 1'b1;
        pop          = data_valid_i;
      end else begin
        rsp_valid_o[headId] = data_valid_i;
        rsp_data_o          = data_i;
        data_ready_o        = rsp_ready_i[headId];
        pop                 = data_valid_i && rsp_ready_i[headId];
      end
    end
  end

  // Arbiter state register: lock, locked requester, sticky flush, rr pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      lockId_q    <= 1'b0;
      flushSeen_q <= 1'b0;
      rrPtr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lockId_q    <= lockId_d;
      flushSeen_q <= flushSeen_d;
      rrPtr_q     <= rrPtr_d;
    end
  end

  // ID FIFO: pointers and occupancy; a full FIFO never accepts a push,
  // even when an entry pops in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ID FIFO storage: a flush marks every slot squashed; the entry pushed in
  // the same cycle carries its own squash bit, which already covers the flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        idMem_q[i] <= 1'b0;
        sqMem_q[i] <= 1'b0;
      end
    end else begin
      if (flush_i) begin
        for (int i = 0; i < MAX_OUT; i++) begin
          sqMem_q[i] <= 1'b1;
        end
      end
      if (push) begin
        idMem_q[wrPtr_q] <= sel;
        sqMem_q[wrPtr_q] <= pushSquash;
      end
    end
  end

`ifdef ICACHE_ARB_PERF_EN
  // Saturating event counters: grants per requester, stalled request
  // cycles, and squashed responses dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant_o  <= '0;
      perf_stall_o  <= '0;
      perf_squash_o <= '0;
    end else begin
      if (push && (perf_grant_o[sel] != '1)) begin
        perf_grant_o[sel] <= perf_grant_o[sel] + 32'd1;
      end
      if ((|req_valid_i) && !push && (perf_stall_o != '1)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
      if (pop && headSq && (perf_squash_o != '1)) begin
        perf_squash_o <= perf_squash_o + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  rspWithoutRequest: assert property (@(posedge clk_i) disable iff (rst_i)
    !(data_valid_i && fifoEmpty));
`endif

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed testbench for icache_req_arbiter (default build, MAX_OUT=4).
module tb_icache_req_arbiter;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic [1:0][31:0] req_addr_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [31:0]      rsp_data_o;
  logic [1:0]       rsp_valid_o;
  logic [1:0]       rsp_ready_i;
  logic [31:0]      addr_o;
  logic             addr_valid_o;
  logic             addr_ready_i;
  logic [31:0]      data_i;
  logic             data_valid_i;
  logic             data_ready_o;

  int nCompared   = 0;
  int nMismatched = 0;

  icache_req_arbiter #(.ADDR_W(32), .MAX_OUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .req_addr_i   (req_addr_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_i = ~clk_i;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task tick;
    @(posedge clk_i);
    #1;
  endtask

  task idle;
    flush_i      = 1'b0;
    req_valid_i  = 2'b00;
    req_addr_i   = '0;
    addr_ready_i = 1'b0;
    rsp_ready_i  = 2'b11;
    data_i       = '0;
    data_valid_i = 1'b0;
  endtask

  task test_reset;
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    nCompared++; if (addr_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_addr_valid: got %b want 0", addr_valid_o); end
    nCompared++; if (req_ready_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready_o); end
    nCompared++; if (rsp_valid_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %b want 00", rsp_valid_o); end
    nCompared++; if (data_ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_data_ready: got %b want 0", data_ready_o); end
    nCompared++; if (rsp_data_o !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rsp_data: got %h want 0", rsp_data_o); end
  endtask

  task test_round_robin;
    logic        expGrant;
    logic        expRoute;
    logic [31:0] expAddr;
    logic [31:0] expData;
    for (int c = 0; c < 8; c++) begin
      req_valid_i   = (c < 6) ? 2'b11 : 2'b00;
      req_addr_i[0] = 32'h100;
      req_addr_i[1] = 32'h200;
      addr_ready_i  = 1'b1;
      rsp_ready_i   = 2'b11;
      data_valid_i  = (c >= 2);
      data_i        = 32'hD000 + c;
      #1;
      if (c < 6) begin
        expGrant = c[0];
        expAddr  = expGrant ? 32'h200 : 32'h100;
        nCompared++; if (addr_o !== expAddr) begin nMismatched++; $display("[TB] FAIL rr_addr c%0d: got %h want %h", c, addr_o, expAddr); end
        nCompared++; if (req_ready_o !== (expGrant ? 2'b10 : 2'b01)) begin nMismatched++; $display("[TB] FAIL rr_req_ready c%0d: got %b want grant %0d", c, req_ready_o, expGrant); end
      end
      if (c >= 2) begin
        expRoute = c[0];
        expData  = 32'hD000 + c;
        nCompared++; if (rsp_valid_o !== (expRoute ? 2'b10 : 2'b01)) begin nMismatched++; $display("[TB] FAIL rr_rsp_valid c%0d: got %b want route %0d", c, rsp_valid_o, expRoute); end
        nCompared++; if (rsp_data_o !== expData) begin nMismatched++; $display("[TB] FAIL rr_rsp_data c%0d: got %h want %h", c, rsp_data_o, expData); end
      end
      tick();
    end
    idle();
  endtask

  task test_lock;
    for (int c = 0; c < 3; c++) begin
      req_valid_i   = 2'b10;
      req_addr_i[1] = 32'h40;
      req_addr_i[0] = 32'h80;
      addr_ready_i  = 1'b0;
      #1;
      nCompared++; if (addr_valid_o !== 1'b1 || addr_o !== 32'h40) begin nMismatched++; $display("[TB] FAIL lock_hold c%0d: got v=%b a=%h want v=1 a=40", c, addr_valid_o, addr_o); end
      nCompared++; if (req_ready_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL lock_no_ready c%0d: got %b want 00", c, req_ready_o); end
      tick();
    end
    req_valid_i = 2'b11;
    #1;
    nCompared++; if (addr_o !== 32'h40) begin nMismatched++; $display("[TB] FAIL lock_stays: got %h want 40", addr_o); end
    tick();
    addr_ready_i = 1'b1;
    #1;
    nCompared++; if (addr_o !== 32'h40 || req_ready_o !== 2'b10) begin nMismatched++; $display("[TB] FAIL lock_accept: got a=%h r=%b want a=40 r=10", addr_o, req_ready_o); end
    tick();
    req_valid_i = 2'b01;
    #1;
    nCompared++; if (addr_o !== 32'h80 || req_ready_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL lock_next: got a=%h r=%b want a=80 r=01", addr_o, req_ready_o); end
    tick();
    idle();
    data_valid_i = 1'b1;
    data_i       = 32'hAA;
    #1;
    nCompared++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== 32'hAA) begin nMismatched++; $display("[TB] FAIL lock_rsp1: got v=%b d=%h want v=10 d=aa", rsp_valid_o, rsp_data_o); end
    tick();
    data_i = 32'hBB;
    #1;
    nCompared++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'hBB) begin nMismatched++; $display("[TB] FAIL lock_rsp0: got v=%b d=%h want v=01 d=bb", rsp_valid_o, rsp_data_o); end
    tick();
    idle();
  endtask

  task test_full;
    for (int c = 0; c < 4; c++) begin
      req_valid_i   = 2'b01;
      req_addr_i[0] = 32'h500;
      addr_ready_i  = 1'b1;
      #1;
      nCompared++; if (req_ready_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL full_fill c%0d: got %b want 01", c, req_ready_o); end
      tick();
    end
    #1;
    nCompared++; if (addr_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL full_block: got v=%b r=%b want v=0 r=00", addr_valid_o, req_ready_o); end
    tick();
    data_valid_i = 1'b1;
    data_i       = 32'h55;
    #1;
    nCompared++; if (addr_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_no_bypass: got %b want 0", addr_valid_o); end
    nCompared++; if (rsp_valid_o !== 2'b01 || data_ready_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_pop: got v=%b dr=%b want v=01 dr=1", rsp_valid_o, data_ready_o); end
    tick();
    data_valid_i = 1'b0;
    #1;
    nCompared++; if (addr_valid_o !== 1'b1 || req_ready_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL full_fifth: got v=%b r=%b want v=1 r=01", addr_valid_o, req_ready_o); end
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      data_valid_i = 1'b1;
      #1;
      nCompared++; if (rsp_valid_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL full_drain c%0d: got %b want 01", c, rsp_valid_o); end
      tick();
    end
    idle();
  endtask

  task test_flush;
    for (int c = 0; c < 3; c++) begin
      req_valid_i   = 2'b10;
      req_addr_i[1] = 32'h600;
      addr_ready_i  = 1'b1;
      tick();
    end
    flush_i       = 1'b1;
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h700;
    #1;
    nCompared++; if (addr_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL flush_no_grant: got v=%b r=%b want v=0 r=00", addr_valid_o, req_ready_o); end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      data_valid_i = 1'b1;
      #1;
      nCompared++; if (data_ready_o !== 1'b1 || rsp_valid_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL flush_drop c%0d: got dr=%b v=%b want dr=1 v=00", c, data_ready_o, rsp_valid_o); end
      tick();
    end
    idle();
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h700;
    addr_ready_i  = 1'b1;
    #1;
    nCompared++; if (req_ready_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL flush_new_req: got %b want 01", req_ready_o); end
    tick();
    idle();
    data_valid_i = 1'b1;
    data_i       = 32'h77;
    #1;
    nCompared++; if (rsp_valid_o !== 2'b01 || rsp_data_o !== 32'h77) begin nMismatched++; $display("[TB] FAIL flush_new_rsp: got v=%b d=%h want v=01 d=77", rsp_valid_o, rsp_data_o); end
    tick();
    idle();
  endtask

  task test_lock_flush;
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h840;
    addr_ready_i  = 1'b0;
    tick();
    flush_i = 1'b1;
    #1;
    nCompared++; if (addr_valid_o !== 1'b1 || addr_o !== 32'h840) begin nMismatched++; $display("[TB] FAIL lflush_present: got v=%b a=%h want v=1 a=840", addr_valid_o, addr_o); end
    tick();
    flush_i      = 1'b0;
    addr_ready_i = 1'b1;
    #1;
    nCompared++; if (req_ready_o !== 2'b10) begin nMismatched++; $display("[TB] FAIL lflush_accept: got %b want 10", req_ready_o); end
    tick();
    idle();
    data_valid_i = 1'b1;
    #1;
    nCompared++; if (data_ready_o !== 1'b1 || rsp_valid_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL lflush_drop: got dr=%b v=%b want dr=1 v=00", data_ready_o, rsp_valid_o); end
    tick();
    idle();
    req_valid_i   = 2'b10;
    req_addr_i[1] = 32'h880;
    addr_ready_i  = 1'b1;
    tick();
    idle();
    data_valid_i = 1'b1;
    data_i       = 32'h99;
    #1;
    nCompared++; if (rsp_valid_o !== 2'b10 || rsp_data_o !== 32'h99) begin nMismatched++; $display("[TB] FAIL lflush_after: got v=%b d=%h want v=10 d=99", rsp_valid_o, rsp_data_o); end
    tick();
    idle();
  endtask

  task test_backpressure;
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'h900;
    addr_ready_i  = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      data_valid_i = 1'b1;
      data_i       = 32'h33;
      rsp_ready_i  = 2'b00;
      #1;
      nCompared++; if (rsp_valid_o !== 2'b01 || data_ready_o !== 1'b0 || rsp_data_o !== 32'h33) begin nMismatched++; $display("[TB] FAIL bp_hold c%0d: got v=%b dr=%b d=%h want v=01 dr=0 d=33", c, rsp_valid_o, data_ready_o, rsp_data_o); end
      tick();
    end
    rsp_ready_i = 2'b01;
    #1;
    nCompared++; if (data_ready_o !== 1'b1 || rsp_valid_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL bp_release: got dr=%b v=%b want dr=1 v=01", data_ready_o, rsp_valid_o); end
    tick();
    idle();
    #1;
    nCompared++; if (data_ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_popped: got %b want 0", data_ready_o); end
  endtask

  task test_reset_mid;
    req_valid_i   = 2'b01;
    req_addr_i[0] = 32'hA00;
    req_addr_i[1] = 32'hA40;
    addr_ready_i  = 1'b1;
    tick();
    tick();
    req_valid_i  = 2'b10;
    addr_ready_i = 1'b0;
    #1;
    nCompared++; if (addr_o !== 32'hA40) begin nMismatched++; $display("[TB] FAIL rmid_lock: got %h want a40", addr_o); end
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle();
    #1;
    nCompared++; if (addr_valid_o !== 1'b0 || req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00 || data_ready_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rmid_outputs: got v=%b r=%b rv=%b dr=%b want all 0", addr_valid_o, req_ready_o, rsp_valid_o, data_ready_o); end
    req_valid_i   = 2'b11;
    req_addr_i[0] = 32'hA00;
    req_addr_i[1] = 32'hA40;
    #1;
    nCompared++; if (addr_o !== 32'hA00) begin nMismatched++; $display("[TB] FAIL rmid_rr_ptr: got %h want a00", addr_o); end
    idle();
    tick();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_flush();
    test_lock_flush();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/icache_req_arbiter.md
Name: icache_req_arbiter

Overview:
- Shares the single i-cache request/response port between two frontend requesters: req 0 = fetch stage (demand), req 1 = next-line prefetcher.
- Arbitrates the address channel round-robin.
- Tracks outstanding requests in an in-order ID FIFO and routes each returning response to the requester that issued it.
- Discards responses belonging to requests issued before a flush. Sits between fetch_stage/prefetcher and the i-cache.

Parameters:
- ADDR_W, XLEN: address width.
- MAX_OUT, 4: max outstanding i-cache requests; power of 2, ≥2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  squash all outstanding requests
- req_addr_i  in  2×ADDR_W  per-requester address
- req_valid_i  in  2  per-requester address valid
- req_ready_o  out  2  per-requester address accepted
- rsp_data_o  out  icache_out_t  response data (shared bus)
- rsp_valid_o  out  2  per-requester response valid
- rsp_ready_i  in  2  per-requester response ready
- addr_o  out  ADDR_W  i-cache address
- addr_valid_o  out  1  i-cache address valid
- addr_ready_i  in  1  i-cache address ready
- data_i  in  icache_out_t  i-cache response
- data_valid_i  in  1  i-cache response valid
- data_ready_o  out  1  i-cache response ready

Behaviour:
- Reset:
  - All outputs 0, ID FIFO empty, squash bits cleared, lock cleared.
  - rr_ptr = 0, so requester 0 has priority on the first contest.
- Arbitration:
  - The requester with req_valid_i set and highest round-robin priority wins.
  - After a grant to requester k, priority goes to requester 1-k.
  - Single valid requester wins regardless of rr_ptr.
- Lock:
  - If addr_valid_o=1 and addr_ready_i=0, the selection is locked: addr_o and the selected requester stay fixed until accepted.
  - Requesters must hold valid/addr until their req_ready_o.
- Acceptance:
  - req_ready_o[k] = addr_ready_i && selected==k && !fifo_full.
  - addr_valid_o = any req_valid_i && !fifo_full.
  - Combinational; zero-cycle address path.
- FIFO push:
  - On addr_valid_o && addr_ready_i, push {id=k, squash=0}.
  - Full blocks push even if a pop occurs the same cycle (no bypass).
- Response routing:
  - Head entry id h, not squashed:
    - rsp_valid_o[h] = data_valid_i.
    - rsp_data_o = data_i.
    - data_ready_o = rsp_ready_i[h].
    - Pop on handshake.
  - Head squashed: data_ready_o=1, rsp_valid_o=0, pop on data_valid_i.
  - FIFO empty: data_ready_o=0, rsp_valid_o=0. data_valid_i here is a protocol error; flagged by assertion.
  - Latency: response combinationally forwarded, zero cycles.
- Flush:
  - In the flush_i cycle, all entries present (including one pushed that same cycle) get squash=1 at the clock edge.
  - A pop in the same cycle is still performed.
  - A locked, unaccepted address continues to be presented (protocol forbids retracting valid).
  - Once accepted, that entry is pushed squashed if flush_i was seen since the lock began (sticky flag cleared on acceptance).
  - No new (unlocked) grant is made while flush_i=1: addr_valid_o=0 unless locked.
- Pointers: wrap modulo MAX_OUT. Count is tracked in $clog2(MAX_OUT)+1 bits.
- Reset mid-operation:
  - Synchronous reset empties the FIFO and drops lock and squash state.
  - The i-cache is assumed to be reset in the same cycle.

Optional Feature:
- ICACHE_ARB_PERF_EN defined:
  - Adds outputs perf_grant_o (2×32): grants per requester.
  - Adds perf_stall_o (32): cycles with a request pending but no grant (full, flush, or addr_ready_i=0).
  - Adds perf_squash_o (32): squashed responses dropped.
  - All reset to 0 and saturate at all-ones.
- Undefined: ports and counters absent; no other behavioural difference.

Test Plan:
- Both requesters valid every cycle, addr_ready_i=1, cache responds after 2 cycles → grants alternate 0,1,0,1; responses routed to rsp_valid_o[0], [1] alternately in issue order.
- Requester 1 only, addr 0x40, addr_ready_i held 0 for 3 cycles, then requester 0 raises valid at 0x80 → addr_o stays 0x40 until accepted; requester 0 granted next cycle.
- Issue 4 requests with no responses (MAX_OUT=4) → addr_valid_o=0, req_ready_o=0 on the 5th; after one response pops, 5th accepted next cycle.
- 3 outstanding, flush_i pulsed for 1 cycle, then 3 responses → data_ready_o=1, rsp_valid_o=0 for all 3; a new request after the flush returns normally.
- Head id=0 response with rsp_ready_i[0]=0 for 2 cycles → data_ready_o=0, data held; pop on the cycle rsp_ready_i[0]=1.
- rst_i asserted with 2 outstanding and lock active → next cycle all outputs 0, FIFO empty, rr_ptr=0.
